out_buffer: RTL and testbench
=============================

// Module: out_buffer
// PURPOSE
//   Parametrised output unit; successor to the single-register OUT port.
//   The CPU writes words from the bus. The block keeps a live display register and a
//   DEPTH-entry FIFO, which a slow external consumer drains via valid/ready.
//   Sits between the shared bus and the off-chip display/serial sink.
//   Overflow is flagged sticky, never silent.
// PARAMETERS
//   WIDTH  16  data width of bus, FIFO entries, display register
//   DEPTH  4   FIFO entries; power of two, >= 2
//   AW     $clog2(DEPTH), localparam (derived, not overridable)
// PORTS
//   clk        in   1       system clock, rising-edge
//   rst        in   1       reset; asynchronous, active-low (0 = reset)
//   out_write  in   1       CPU write strobe; bus sampled on rising clk
//   bus        in   WIDTH   data from shared bus
//   out_clear  in   1       synchronous FIFO flush
//   out_ready  in   1       consumer ready to take out_data
//   out_valid  out  1       FIFO non-empty; out_data is valid
//   out_data   out  WIDTH   head-of-FIFO word (show-ahead)
//   _out_      out  WIDTH   display register: last word written by CPU
//   full       out  1       count == DEPTH
//   empty      out  1       count == 0
//   count      out  AW+1    entries held, 0..DEPTH
//   overflow   out  1       sticky: a write was dropped because FIFO full
// BEHAVIOUR
//   Reset (rst=0, async, immediate):
//     - wr_ptr=rd_ptr=0, count=0, _out_=0, overflow=0
//     - hence out_valid=0, out_data=0, full=0, empty=1
//     - storage array contents need not be reset.
//   Display register:
//     - _out_ <= bus on every edge with out_write=1, whether FIFO is full or not
//     - latency 1 edge
//     - out_clear does not affect _out_.
//   push = out_write & (~full | pop);   pop = out_valid & out_ready.
//   Push: mem[wr_ptr] <= bus; wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
//   Pop: rd_ptr <= rd_ptr+1, wrapping mod DEPTH.
//   count: +1 on push only, -1 on pop only, unchanged on both or neither.
//   Outputs, all combinational from registers; no input-to-output comb path:
//     - out_valid = (count != 0)
//     - out_data = empty ? 0 : mem[rd_ptr]
//   First-word latency: word pushed at edge N is visible on out_data/out_valid after edge N.
//     No same-cycle bypass when empty.
//   Full + write + pop same edge: head popped, new word pushed, count stays DEPTH, no overflow.
//   Full + write, no pop:
//     - word dropped, FIFO unchanged, overflow <= 1
//     - _out_ still updates.
//   Empty + out_ready: no pop, pointers unchanged.
//   out_clear=1 at an edge:
//     - wr_ptr=rd_ptr=0, count=0, overflow=0
//     - overrides push/pop/overflow-set in that cycle
//     - _out_ still loads if out_write=1.
//   overflow clears only on reset or out_clear.
//   Async reset mid-transfer: all state above returns to reset values at once; in-flight words lost.
// TESTING  (WIDTH=16, DEPTH=4)
//   1. rst=0 pulse, then rst=1 -> _out_=0, count=0, empty=1, out_valid=0, out_data=0, overflow=0.
//   2. bus=74, out_write=1 for one edge, out_ready=0
//      -> after edge: _out_=74, out_valid=1, out_data=74, count=1.
//   3. out_ready=0; write 1,2,3,4,5 on consecutive edges
//      -> full=1 after 4th; 5th dropped, overflow=1, _out_=5, count=4.
//   4. From (3): out_ready=1, no writes -> out_data 1,2,3,4 on successive cycles.
//      Then empty=1, out_data=0, overflow still 1.
//   5. Full FIFO {1,2,3,4}, out_ready=1, write 9 same edge
//      -> count=4, out_data=2, overflow unchanged.
//      Continue draining -> 3,4,9.
//   6. Partially filled, out_clear=1 with out_write=1, bus=7 -> count=0, overflow=0, _out_=7.
//      Separately: rst=0 mid-drain, asynchronous, between edges -> outputs reset immediately.

Source files
------------

// File: rtl/out_buffer_if.sv
// Bus-side port bundle for out_buffer: CPU write path, consumer handshake and status.
// Handshake: a word transfers on a rising edge where out_valid=1 and out_ready=1; out_data holds the head word while out_valid=1.
interface out_buffer_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
);
   localparam int AW = $clog2(DEPTH);

   logic             out_write;
   logic [WIDTH-1:0] bus;
   logic             out_clear;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [WIDTH-1:0] _out_;
   logic             full;
   logic             empty;
   logic [AW:0]      count;
   logic             overflow;

   modport master (
      output out_write, bus, out_clear, out_ready,
      input  out_valid, out_data, _out_, full, empty, count, overflow
   );

   modport slave (
      input  out_write, bus, out_clear, out_ready,
      output out_valid, out_data, _out_, full, empty, count, overflow
   );
endinterface

// File: rtl/out_buffer.sv
// Output unit: live display register plus a DEPTH-entry show-ahead FIFO drained by a slow consumer.
// A write into a full FIFO without a simultaneous pop is dropped and sets a sticky overflow flag.
module out_buffer #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   out_buffer_if.slave io
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic [WIDTH-1:0] disp;
   logic             ovf;
   logic             full_w;
   logic             empty_w;
   logic             push;
   logic             pop;

   assign full_w  = (cnt == FULL_CNT);
   assign empty_w = (cnt == '0);
   assign pop     = !empty_w && io.out_ready;
   // A pop frees a slot in the same edge, so a full FIFO can still accept a write.
   assign push    = io.out_write && (!full_w || pop);

   always_ff @(posedge clk) begin
      if (push && !io.out_clear) begin
         mem[wr_ptr] <= io.bus;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else if (io.out_clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            cnt <= cnt + (AW+1)'(1);
         end else if (pop && !push) begin
            cnt <= cnt - (AW+1)'(1);
         end
         if (io.out_write && !push) begin
            ovf <= 1'b1;
         end
      end
   end

   // The display register follows every CPU write, regardless of FIFO state or flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp <= '0;
      end else if (io.out_write) begin
         disp <= io.bus;
      end
   end

   assign io.out_valid = !empty_w;
   assign io.out_data  = empty_w ? '0 : mem[rd_ptr];
   assign io._out_     = disp;
   assign io.full      = full_w;
   assign io.empty     = empty_w;
   assign io.count     = cnt;
   assign io.overflow  = ovf;
endmodule

// File: tb/tb_out_buffer.sv
// Bench for out_buffer: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_out_buffer;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic clk;
   logic rst;
   out_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ob ();

   out_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .io  (ob)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit chk_en    = 1'b0;

   // reference model
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] m_disp;
   bit               m_ovf;

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_disp = '0;
      m_ovf  = 1'b0;
   endtask

   task automatic model_edge(input bit w, input logic [WIDTH-1:0] b, input bit c, input bit r);
      bit do_pop;
      bit do_push;
      do_pop  = (exp_q.size() != 0) && r;
      do_push = w && ((exp_q.size() < DEPTH) || do_pop);
      if (w) m_disp = b;
      if (c) begin
         exp_q.delete();
         m_ovf = 1'b0;
      end else begin
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(b);
         else if (w) m_ovf = 1'b1;
      end
   endtask

   // driver: one clock edge with the given inputs; returns at the following falling edge
   task automatic step(input bit w, input logic [WIDTH-1:0] b, input bit c, input bit r);
      ob.out_write = w;
      ob.bus       = b;
      ob.out_clear = c;
      ob.out_ready = r;
      @(posedge clk);
      model_edge(w, b, c, r);
      @(negedge clk);
   endtask

   task automatic do_reset();
      ob.out_write = 1'b0;
      ob.bus       = '0;
      ob.out_clear = 1'b0;
      ob.out_ready = 1'b0;
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // compare process
   always @(negedge clk) begin
      if (chk_en) begin
         int n;
         n = exp_q.size();
         check("out_valid", int'(ob.out_valid), int'(n != 0));
         check("out_data",  int'(ob.out_data),  (n != 0) ? int'(exp_q[0]) : 0);
         check("_out_",     int'(ob._out_),     int'(m_disp));
         check("full",      int'(ob.full),      int'(n == DEPTH));
         check("empty",     int'(ob.empty),     int'(n == 0));
         check("count",     int'(ob.count),     n);
         check("overflow",  int'(ob.overflow),  int'(m_ovf));
      end
   end

   initial begin
      rst = 1'b0;
      ob.out_write = 1'b0;
      ob.bus       = '0;
      ob.out_clear = 1'b0;
      ob.out_ready = 1'b0;
      model_reset();
      do_reset();
      chk_en = 1'b1;

      // reset state
      check("rst _out_", int'(ob._out_), 0);
      check("rst count", int'(ob.count), 0);
      check("rst empty", int'(ob.empty), 1);
      check("rst valid", int'(ob.out_valid), 0);
      check("rst data", int'(ob.out_data), 0);
      check("rst ovf", int'(ob.overflow), 0);

      // single write
      step(1, 16'd74, 0, 0);
      check("w1 _out_", int'(ob._out_), 74);
      check("w1 valid", int'(ob.out_valid), 1);
      check("w1 data", int'(ob.out_data), 74);
      check("w1 count", int'(ob.count), 1);
      step(0, 0, 1, 0);

      // fill past capacity
      for (int i = 1; i <= 5; i++) begin
         step(1, 16'(i), 0, 0);
         if (i == 4) check("fill full", int'(ob.full), 1);
      end
      check("ovf set", int'(ob.overflow), 1);
      check("ovf _out_", int'(ob._out_), 5);
      check("ovf count", int'(ob.count), 4);

      // drain in order
      for (int i = 1; i <= 4; i++) begin
         check("drain data", int'(ob.out_data), i);
         step(0, 0, 0, 1);
      end
      check("drained empty", int'(ob.empty), 1);
      check("drained data", int'(ob.out_data), 0);
      check("drained ovf", int'(ob.overflow), 1);

      // full + write + pop same edge
      step(0, 0, 1, 0);
      for (int i = 1; i <= 4; i++) step(1, 16'(i), 0, 0);
      step(1, 16'd9, 0, 1);
      check("fwp count", int'(ob.count), 4);
      check("fwp data", int'(ob.out_data), 2);
      check("fwp ovf", int'(ob.overflow), 0);
      step(0, 0, 0, 1);
      check("fwp d3", int'(ob.out_data), 3);
      step(0, 0, 0, 1);
      check("fwp d4", int'(ob.out_data), 4);
      step(0, 0, 0, 1);
      check("fwp d9", int'(ob.out_data), 9);
      step(0, 0, 0, 1);

      // clear with simultaneous write, after overflow
      for (int i = 1; i <= 5; i++) step(1, 16'(i + 20), 0, 0);
      step(1, 16'd7, 1, 0);
      check("clr count", int'(ob.count), 0);
      check("clr ovf", int'(ob.overflow), 0);
      check("clr _out_", int'(ob._out_), 7);

      // async reset between edges while draining
      for (int i = 1; i <= 3; i++) step(1, 16'(i + 40), 0, 0);
      step(0, 0, 0, 1);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("arst count", int'(ob.count), 0);
      check("arst valid", int'(ob.out_valid), 0);
      check("arst data", int'(ob.out_data), 0);
      check("arst _out_", int'(ob._out_), 0);
      check("arst empty", int'(ob.empty), 1);
      ob.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // random traffic
      for (int k = 0; k < 2000; k++) begin
         step(bit'($urandom_range(0, 99) < 55), 16'($urandom),
              bit'($urandom_range(0, 99) < 3), bit'($urandom_range(0, 99) < 45));
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
